// File: rtl/axi_node_pkg.sv
// ---------------------------------------------------------------------------
// axi_node_pkg
// Shared definitions for the axi_node arbiters.
//   arb_state_e     : burst arbiter state (IDLE = free to arbitrate,
//                     LOCKED = grant held until the RLAST handshake)
//   MAX_BURST_BEATS : longest legal AXI4 burst; a longer burst flags an error
//   BEAT_CNT_W      : width of the per-burst beat counter (holds 0..256)
// ---------------------------------------------------------------------------
package axi_node_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_BURST_BEATS = 256;
    localparam int BEAT_CNT_W      = 9;

endpackage : axi_node_pkg

// File: rtl/axi_rr_pick.sv
// ---------------------------------------------------------------------------
// axi_rr_pick
// Combinational cyclic priority encoder: returns the first asserted request
// at or after ptr_i, wrapping from N-1 back to 0.
//   req_i   in  [N]      request vector
//   ptr_i   in  [IDX_W]  highest-priority position (must be < N)
//   valid_o out  1       at least one request asserted
//   idx_o   out [IDX_W]  winning index; equals ptr_i when valid_o is 0
// ---------------------------------------------------------------------------
module axi_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Rotate the request vector so position 0 is the pointer, then a plain
    // lowest-set-bit search gives the cyclic winner.
    logic [N-1:0] req_rot;
    logic [IDX_W:0] sum;

    assign req_rot = N'({req_i, req_i} >> ptr_i);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = ptr_i;
        sum     = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_rot[i]) begin
                valid_o = 1'b1;
                sum     = {1'b0, ptr_i} + (IDX_W + 1)'(i);
                if (sum >= (IDX_W + 1)'(N)) begin
                    sum = sum - (IDX_W + 1)'(N);
                end
                idx_o = sum[IDX_W-1:0];
            end
        end
    end

endmodule : axi_rr_pick

// File: rtl/axi_r_burst_arbiter.sv
// ---------------------------------------------------------------------------
// axi_r_burst_arbiter
// Burst-locked round-robin arbiter sharing one AXI R channel between
// N_INIT_PORT response sources. A source is chosen per burst and keeps the
// channel until its RLAST beat is accepted. Beats per burst are counted and
// a burst running past 256 beats sets a sticky error flag.
//
// Ports (per-source buses are flattened, source i at slice i):
//   clk, rst_n      clock, asynchronous active-low reset
//   rid_i/rdata_i/rresp_i/rlast_i/ruser_i/rvalid_i   per-source R inputs
//   rready_o        per-source RREADY, only the selected source sees rready_i
//   rid_o/rdata_o/rresp_o/rlast_o/ruser_o/rvalid_o   muxed R output
//   rready_i        downstream RREADY
//   grant_idx_o     owner when locked, else arbitration winner (or rr_ptr)
//   locked_o        grant is held for an unfinished burst
//   burst_err_o     sticky: a burst exceeded 256 beats
// ---------------------------------------------------------------------------
module axi_r_burst_arbiter
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int AXI_ID_W    = 16,
    parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic [N_INIT_PORT*AXI_ID_W-1:0]   rid_i,
    input  logic [N_INIT_PORT*AXI_DATA_W-1:0] rdata_i,
    input  logic [N_INIT_PORT*2-1:0]          rresp_i,
    input  logic [N_INIT_PORT-1:0]            rlast_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] ruser_i,
    input  logic [N_INIT_PORT-1:0]            rvalid_i,
    output logic [N_INIT_PORT-1:0]            rready_o,

    output logic [AXI_ID_W-1:0]               rid_o,
    output logic [AXI_DATA_W-1:0]             rdata_o,
    output logic [1:0]                        rresp_o,
    output logic                              rlast_o,
    output logic [AXI_USER_W-1:0]             ruser_o,
    output logic                              rvalid_o,
    input  logic                              rready_i,

    output logic [LOG_N_INIT-1:0]             grant_idx_o,
    output logic                              locked_o,
    output logic                              burst_err_o
);

    localparam int PAY_W = AXI_USER_W + 1 + 2 + AXI_DATA_W + AXI_ID_W;
    // Mux table padded to a power of two so the select index is exactly
    // LOG_N_INIT bits wide; padding entries are never selected.
    localparam int PAD_N = 1 << LOG_N_INIT;

    localparam logic [BEAT_CNT_W-1:0] BEAT_LAST_LEGAL = BEAT_CNT_W'(MAX_BURST_BEATS - 1);
    localparam logic [BEAT_CNT_W-1:0] BEAT_SAT        = BEAT_CNT_W'(MAX_BURST_BEATS);

    // Control state
    arb_state_e              state_q, state_d;
    logic [LOG_N_INIT-1:0]   owner_q, owner_d;
    logic [LOG_N_INIT-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                    burst_err_q, burst_err_d;

    logic                    pick_vld;
    logic [LOG_N_INIT-1:0]   pick_idx;
    logic [LOG_N_INIT-1:0]   sel_idx;
    logic                    fwd_en;
    logic                    hs;

    logic [PAY_W-1:0]        payload [PAD_N];
    logic [PAD_N-1:0]        rvalid_pad;
    logic [PAY_W-1:0]        payload_sel;

    function automatic logic [LOG_N_INIT-1:0] next_idx(input logic [LOG_N_INIT-1:0] idx);
        if ({1'b0, idx} >= (LOG_N_INIT + 1)'(N_INIT_PORT - 1)) begin
            return '0;
        end
        return idx + LOG_N_INIT'(1);
    endfunction

    axi_rr_pick #(
        .N     (N_INIT_PORT),
        .IDX_W (LOG_N_INIT)
    ) u_pick (
        .req_i   (rvalid_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    // Pack each source as {ruser, rlast, rresp, rdata, rid}
    always_comb begin
        rvalid_pad                = '0;
        rvalid_pad[N_INIT_PORT-1:0] = rvalid_i;
        for (int i = 0; i < PAD_N; i++) begin
            payload[i] = '0;
        end
        for (int i = 0; i < N_INIT_PORT; i++) begin
            payload[i] = {ruser_i[i*AXI_USER_W +: AXI_USER_W],
                          rlast_i[i],
                          rresp_i[i*2 +: 2],
                          rdata_i[i*AXI_DATA_W +: AXI_DATA_W],
                          rid_i[i*AXI_ID_W +: AXI_ID_W]};
        end
    end

    // Selection: the owner while locked, otherwise the arbitration winner.
    // With no request pick_idx already equals rr_ptr_q.
    assign sel_idx     = (state_q == LOCKED) ? owner_q : pick_idx;
    assign fwd_en      = (state_q == LOCKED) || pick_vld;
    assign grant_idx_o = sel_idx;
    assign payload_sel = payload[sel_idx];

    assign {ruser_o, rlast_o, rresp_o, rdata_o, rid_o} = payload_sel;
    assign rvalid_o = fwd_en && rvalid_pad[sel_idx];
    assign hs       = rvalid_o && rready_i;

    always_comb begin
        rready_o = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            rready_o[i] = fwd_en && (sel_idx == LOG_N_INIT'(i)) && rready_i;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign burst_err_o = burst_err_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_err_d = burst_err_q;

        // A non-last beat accepted after 255 already means the burst is
        // over length; keep the lock and just flag it.
        if (hs && !rlast_o && (beat_cnt_q == BEAT_LAST_LEGAL)) begin
            burst_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    if (hs && rlast_o) begin
                        rr_ptr_d   = next_idx(pick_idx);
                        beat_cnt_d = '0;
                    end else begin
                        // Lock even without a handshake so the presented
                        // beat cannot be pre-empted by another source.
                        state_d = LOCKED;
                        owner_d = pick_idx;
                        if (hs) begin
                            beat_cnt_d = BEAT_CNT_W'(1);
                        end
                    end
                end
            end
            LOCKED: begin
                if (hs) begin
                    if (rlast_o) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_idx(owner_q);
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q < BEAT_SAT) begin
                        beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

endmodule : axi_r_burst_arbiter

// File: tb/tb_axi_r_burst_arbiter.sv
module tb_axi_r_burst_arbiter;

    localparam int N  = 4;
    localparam int D  = 64;
    localparam int U  = 6;
    localparam int ID = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Source-side stimulus (per source)
    logic [N-1:0]  src_vld;
    logic [N-1:0]  src_last;
    logic [ID-1:0] src_id   [N];
    logic [D-1:0]  src_data [N];
    logic [1:0]    src_resp [N];
    logic [U-1:0]  src_user [N];
    logic          rready_in;

    logic [N*ID-1:0] rid_flat;
    logic [N*D-1:0]  rdata_flat;
    logic [N*2-1:0]  rresp_flat;
    logic [N*U-1:0]  ruser_flat;

    always_comb begin
        rid_flat   = '0;
        rdata_flat = '0;
        rresp_flat = '0;
        ruser_flat = '0;
        for (int i = 0; i < N; i++) begin
            rid_flat[i*ID +: ID] = src_id[i];
            rdata_flat[i*D +: D] = src_data[i];
            rresp_flat[i*2 +: 2] = src_resp[i];
            ruser_flat[i*U +: U] = src_user[i];
        end
    end

    logic [N-1:0]  rready_o;
    logic [ID-1:0] rid_o;
    logic [D-1:0]  rdata_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic [U-1:0]  ruser_o;
    logic          rvalid_o;
    logic [1:0]    grant_idx_o;
    logic          locked_o;
    logic          burst_err_o;

    axi_r_burst_arbiter #(
        .N_INIT_PORT (N), .AXI_DATA_W (D), .AXI_USER_W (U), .AXI_ID_W (ID)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .rid_i (rid_flat), .rdata_i (rdata_flat), .rresp_i (rresp_flat),
        .rlast_i (src_last), .ruser_i (ruser_flat), .rvalid_i (src_vld),
        .rready_o (rready_o),
        .rid_o (rid_o), .rdata_o (rdata_o), .rresp_o (rresp_o), .rlast_o (rlast_o),
        .ruser_o (ruser_o), .rvalid_o (rvalid_o), .rready_i (rready_in),
        .grant_idx_o (grant_idx_o), .locked_o (locked_o), .burst_err_o (burst_err_o)
    );

    // Single-source build: must behave as a pass-through
    logic          v1, l1, rdy_i1;
    logic [D-1:0]  d1;
    logic [ID-1:0] id1;
    logic [1:0]    resp1;
    logic [U-1:0]  user1;
    logic [0:0]    rready_o1;
    logic [ID-1:0] rid_o1;
    logic [D-1:0]  rdata_o1;
    logic [1:0]    rresp_o1;
    logic          rlast_o1;
    logic [U-1:0]  ruser_o1;
    logic          rvalid_o1;
    logic [0:0]    grant_o1;
    logic          locked_o1;
    logic          berr_o1;

    axi_r_burst_arbiter #(
        .N_INIT_PORT (1), .AXI_DATA_W (D), .AXI_USER_W (U), .AXI_ID_W (ID)
    ) dut1 (
        .clk (clk), .rst_n (rst_n),
        .rid_i (id1), .rdata_i (d1), .rresp_i (resp1),
        .rlast_i (l1), .ruser_i (user1), .rvalid_i (v1),
        .rready_o (rready_o1),
        .rid_o (rid_o1), .rdata_o (rdata_o1), .rresp_o (rresp_o1), .rlast_o (rlast_o1),
        .ruser_o (ruser_o1), .rvalid_o (rvalid_o1), .rready_i (rdy_i1),
        .grant_idx_o (grant_o1), .locked_o (locked_o1), .burst_err_o (berr_o1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who holds the channel, where the round-robin search
    // starts next, how many beats the current burst has delivered.
    bit m_locked, m_err;
    int m_owner, m_rr, m_beats;
    bit n_locked, n_err;
    int n_owner, n_rr, n_beats;
    int acc, last_acc;

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    endtask

    task automatic set_beat(input logic [1:0] i, input logic last);
        src_vld[i]  = 1'b1;
        src_last[i] = last;
        src_id[i]   = ID'($urandom);
        src_data[i] = {$urandom, $urandom};
        src_resp[i] = 2'($urandom);
        src_user[i] = U'($urandom);
    endtask

    // Called at the falling edge: compare outputs, then predict the effect
    // of the coming rising edge.
    task automatic sample();
        int g;
        bit have;
        bit exp_vld;
        bit hs;
        logic [1:0] gi;
        logic [N-1:0] exp_rdy;
        have = 0;
        g = m_rr;
        if (m_locked) begin
            g = m_owner;
            have = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!have && src_vld[2'((m_rr + k) % N)]) begin
                    g = (m_rr + k) % N;
                    have = 1;
                end
            end
        end
        gi = 2'(g);
        exp_vld = have && src_vld[gi];
        exp_rdy = '0;
        if (have) exp_rdy[gi] = rready_in;

        chk("grant_idx", 128'(grant_idx_o), 128'(g));
        chk("rvalid", 128'(rvalid_o), 128'(exp_vld));
        chk("rready", 128'(rready_o), 128'(exp_rdy));
        chk("locked", 128'(locked_o), 128'(m_locked));
        chk("burst_err", 128'(burst_err_o), 128'(m_err));
        if (exp_vld) begin
            chk("rdata", 128'(rdata_o), 128'(src_data[gi]));
            chk("rid", 128'(rid_o), 128'(src_id[gi]));
            chk("rlast", 128'(rlast_o), 128'(src_last[gi]));
            chk("rresp", 128'(rresp_o), 128'(src_resp[gi]));
            chk("ruser", 128'(ruser_o), 128'(src_user[gi]));
        end

        hs  = exp_vld && rready_in;
        acc = hs ? g : -1;
        n_locked = m_locked; n_owner = m_owner; n_rr = m_rr;
        n_beats = m_beats; n_err = m_err;
        if (hs) begin
            if (src_last[gi]) begin
                n_locked = 0;
                n_rr = (g + 1) % N;
                n_beats = 0;
            end else begin
                n_locked = 1;
                n_owner = g;
                n_beats = m_beats + 1;
                if (n_beats > 255) n_err = 1;
            end
        end else if (have) begin
            n_locked = 1;
            n_owner = g;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        m_locked = n_locked; m_owner = n_owner; m_rr = n_rr;
        m_beats = n_beats; m_err = n_err;
        last_acc = acc;
        #1;
        if (acc >= 0) src_vld[2'(acc)] = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        adv();
    endtask

    int rem [N];
    bit m1_locked;
    bit hs1;
    int sent;

    initial begin
        src_vld = '0; src_last = '0; rready_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_id[i] = '0; src_data[i] = '0; src_resp[i] = '0; src_user[i] = '0;
            rem[i] = 0;
        end
        v1 = 0; l1 = 0; rdy_i1 = 0; d1 = '0; id1 = 16'h1234; resp1 = 2'b01; user1 = 6'h2a;
        model_reset();
        m1_locked = 0;
        acc = -1; last_acc = -1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 128'(grant_idx_o), 128'(0));
        chk("rst_locked", 128'(locked_o), 128'(0));
        chk("rst_berr", 128'(burst_err_o), 128'(0));
        chk("rst_rvalid", 128'(rvalid_o), 128'(0));
        chk("rst_rready", 128'(rready_o), 128'(0));
        chk("rst_locked1", 128'(locked_o1), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sources 1 and 3 each with a single-beat burst
        rready_in = 1'b1;
        set_beat(2'd1, 1'b1);
        set_beat(2'd3, 1'b1);
        @(negedge clk); sample(); chk("t1_first", 128'(grant_idx_o), 128'(1)); adv();
        @(negedge clk); sample(); chk("t1_second", 128'(grant_idx_o), 128'(3)); adv();
        @(negedge clk); sample(); chk("t1_rr_wrap", 128'(grant_idx_o), 128'(0)); adv();

        // Source 2 four-beat burst while source 0 waits
        set_beat(2'd2, 1'b0);
        @(negedge clk); sample(); chk("t2_grant", 128'(grant_idx_o), 128'(2)); adv();
        set_beat(2'd0, 1'b1);
        for (int b = 2; b <= 4; b++) begin
            set_beat(2'd2, logic'(b == 4));
            @(negedge clk); sample();
            chk("t2_src0_blocked", 128'(rready_o[0]), 128'(0));
            chk("t2_locked", 128'(locked_o), 128'(1));
            adv();
        end
        @(negedge clk); sample();
        chk("t2_src0_next", 128'(grant_idx_o), 128'(0));
        chk("t2_src0_rdy", 128'(rready_o[0]), 128'(1));
        adv();

        // Back-pressure: source 1 held while source 0 appears
        rready_in = 1'b0;
        set_beat(2'd1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) set_beat(2'd0, 1'b1);
            @(negedge clk); sample();
            chk("t3_grant", 128'(grant_idx_o), 128'(1));
            chk("t3_rdata", 128'(rdata_o), 128'(src_data[1]));
            adv();
        end
        rready_in = 1'b1;
        step();
        @(negedge clk); sample(); chk("t3_then_src0", 128'(grant_idx_o), 128'(0)); adv();

        // Over-length burst from source 3
        for (int b = 1; b <= 257; b++) begin
            set_beat(2'd3, 1'b0);
            @(negedge clk); sample();
            chk("t4_berr", 128'(burst_err_o), 128'(b >= 257));
            chk("t4_grant", 128'(grant_idx_o), 128'(3));
            adv();
        end
        set_beat(2'd3, 1'b1);
        step();
        @(negedge clk); sample(); chk("t4_sticky", 128'(burst_err_o), 128'(1)); adv();

        // Reset during beat 2 of an 8-beat burst from source 2
        set_beat(2'd2, 1'b0);
        step();
        set_beat(2'd2, 1'b0);
        #2 rst_n = 1'b0;
        src_vld = '0;
        #1;
        chk("t5_locked", 128'(locked_o), 128'(0));
        chk("t5_berr", 128'(burst_err_o), 128'(0));
        chk("t5_rr", 128'(grant_idx_o), 128'(0));
        chk("t5_rvalid", 128'(rvalid_o), 128'(0));
        model_reset();
        m1_locked = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        set_beat(2'd1, 1'b1);
        @(negedge clk); sample();
        chk("t5_rearb", 128'(grant_idx_o), 128'(1));
        chk("t5_idle", 128'(locked_o), 128'(0));
        adv();

        // Randomized traffic, AXI-legal sources (payload stable until accepted)
        last_acc = -1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (last_acc == i) rem[i] = rem[i] - 1;
                if (!src_vld[i] && $urandom_range(0, 3) != 0) begin
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 6);
                    set_beat(2'(i), logic'(rem[i] == 1));
                end
            end
            rready_in = ($urandom_range(0, 3) != 0);
            step();
        end
        src_vld = '0;
        rready_in = 1'b0;

        // Single-source build: 3-beat burst with toggling rready
        sent = 0;
        d1 = {$urandom, $urandom};
        for (int c = 0; c < 40 && sent < 3; c++) begin
            v1 = 1'b1;
            l1 = (sent == 2);
            rdy_i1 = logic'(c % 2);
            @(negedge clk);
            chk("n1_rready", 128'(rready_o1), 128'(rdy_i1));
            chk("n1_rvalid", 128'(rvalid_o1), 128'(1));
            chk("n1_rdata", 128'(rdata_o1), 128'(d1));
            chk("n1_rlast", 128'(rlast_o1), 128'(l1));
            chk("n1_grant", 128'(grant_o1), 128'(0));
            chk("n1_locked", 128'(locked_o1), 128'(m1_locked));
            hs1 = rdy_i1;
            if (hs1 && l1) m1_locked = 0;
            else m1_locked = 1;
            @(posedge clk); #1;
            if (hs1) begin
                sent++;
                d1 = {$urandom, $urandom};
            end
        end
        chk("n1_beats_sent", 128'(sent), 128'(3));
        v1 = 1'b0;
        @(negedge clk);
        chk("n1_done_unlocked", 128'(locked_o1), 128'(0));
        chk("n1_berr", 128'(berr_o1), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axi_r_burst_arbiter
